// File: rtl/ldpc_led_reporter.sv
// ldpc_led_reporter
// Shows a decoded LDPC codeword on one LED. A word is accepted over a
// valid/ready handshake into a one-deep pending buffer. It is then displayed
// either as a serial blink frame (long on = 1, short on = 0, LSB first) or as
// a plain level showing bit 0.
//
// Ports
//   clk        : single clock domain (48 MHz HFOSC)
//   rst_n      : asynchronous active-low reset
//   word_valid : decoder presents a codeword
//   word_data  : codeword, bit i = corrected_seq[i]
//   word_ready : pending buffer empty
//   mode       : 0 = level mode (bit 0), 1 = serial frame mode
//   led        : registered LED drive
//   busy       : FSM is not in IDLE
//   bit_idx    : index of the bit currently being shown
module ldpc_led_reporter #(
  parameter int N               = 10,
  parameter int TICK_DIV        = 24000000,
  parameter int LONG_TICKS      = 3,
  parameter int SHORT_TICKS     = 1,
  parameter int GAP_TICKS       = 1,
  parameter int FRAME_GAP_TICKS = 4,
  localparam int IW             = (N > 1) ? $clog2(N) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          word_valid,
  input  logic [N-1:0]  word_data,
  output logic          word_ready,
  input  logic          mode,
  output logic          led,
  output logic          busy,
  output logic [IW-1:0] bit_idx
);

  localparam int TW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int MAXA = (LONG_TICKS > GAP_TICKS) ? LONG_TICKS : GAP_TICKS;
  localparam int MAXT = (MAXA > FRAME_GAP_TICKS) ? MAXA : FRAME_GAP_TICKS;
  localparam int CW   = $clog2(MAXT + 1);

  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST  = IW'(N - 1);
  localparam logic [CW-1:0] LONG_LAST = CW'(LONG_TICKS - 1);
  localparam logic [CW-1:0] SHRT_LAST = CW'(SHORT_TICKS - 1);
  localparam logic [CW-1:0] GAP_LAST  = CW'(GAP_TICKS - 1);
  localparam logic [CW-1:0] FGAP_LAST = CW'(FRAME_GAP_TICKS - 1);

  typedef enum logic [1:0] {S_IDLE, S_ON, S_GAP, S_FGAP} state_t;

  state_t          r_state, w_state_nx;
  logic [TW-1:0]   r_tick_cnt;
  logic [CW-1:0]   r_dur, w_dur_nx;
  logic [IW-1:0]   r_idx, w_idx_nx;
  logic            r_led, w_led_nx;
  logic [N-1:0]    r_pending, r_frame;
  logic            r_pending_v, r_have_frame;
  logic            w_tick, w_xfer, w_load;
  logic [CW-1:0]   w_on_last;

  assign w_tick     = (r_tick_cnt == TICK_LAST);
  assign w_xfer     = word_valid && !r_pending_v;
  assign w_on_last  = r_frame[r_idx] ? LONG_LAST : SHRT_LAST;

  assign word_ready = !r_pending_v;
  assign led        = r_led;
  assign busy       = (r_state != S_IDLE);
  assign bit_idx    = r_idx;

  // Free-running display tick divider.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_tick_cnt <= '0;
    else if (w_tick) r_tick_cnt <= '0;
    else r_tick_cnt <= r_tick_cnt + TW'(1);
  end

  // Next-state logic. Everything except the handshake only moves on a tick.
  always_comb begin
    w_state_nx = r_state;
    w_dur_nx   = r_dur;
    w_idx_nx   = r_idx;
    w_led_nx   = r_led;
    w_load     = 1'b0;
    if (w_tick) begin
      if (!mode) begin
        // Level mode: pending (if any) is loaded and its bit 0 shown directly.
        w_state_nx = S_IDLE;
        w_dur_nx   = '0;
        w_idx_nx   = '0;
        w_load     = r_pending_v;
        w_led_nx   = r_pending_v ? r_pending[0] : (r_have_frame & r_frame[0]);
      end else begin
        case (r_state)
          S_IDLE: begin
            w_led_nx = 1'b0;
            if (r_pending_v || r_have_frame) begin
              w_load     = r_pending_v;
              w_idx_nx   = '0;
              w_dur_nx   = '0;
              w_state_nx = S_ON;
              w_led_nx   = 1'b1;
            end
          end
          S_ON: begin
            if (r_dur == w_on_last) begin
              w_dur_nx   = '0;
              w_state_nx = S_GAP;
              w_led_nx   = 1'b0;
            end else begin
              w_dur_nx = r_dur + CW'(1);
            end
          end
          S_GAP: begin
            if (r_dur == GAP_LAST) begin
              w_dur_nx = '0;
              if (r_idx != IDX_LAST) begin
                w_idx_nx   = r_idx + IW'(1);
                w_state_nx = S_ON;
                w_led_nx   = 1'b1;
              end else begin
                w_state_nx = S_FGAP;
                w_led_nx   = 1'b0;
              end
            end else begin
              w_dur_nx = r_dur + CW'(1);
            end
          end
          S_FGAP: begin
            if (r_dur == FGAP_LAST) begin
              // Frame boundary: take a waiting word, else replay this frame.
              w_load     = r_pending_v;
              w_idx_nx   = '0;
              w_dur_nx   = '0;
              w_state_nx = S_ON;
              w_led_nx   = 1'b1;
            end else begin
              w_dur_nx = r_dur + CW'(1);
            end
          end
          default: begin
            w_state_nx = S_IDLE;
            w_led_nx   = 1'b0;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_dur   <= '0;
      r_idx   <= '0;
      r_led   <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_dur   <= w_dur_nx;
      r_idx   <= w_idx_nx;
      r_led   <= w_led_nx;
    end
  end

  // Load only happens with pending_v=1 and a transfer only with pending_v=0,
  // so a same-edge load always uses the old pending word and the new word
  // simply refills the buffer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pending    <= '0;
      r_pending_v  <= 1'b0;
      r_frame      <= '0;
      r_have_frame <= 1'b0;
    end else begin
      if (w_load) begin
        r_frame      <= r_pending;
        r_have_frame <= 1'b1;
      end
      if (w_xfer) begin
        r_pending   <= word_data;
        r_pending_v <= 1'b1;
      end else if (w_load) begin
        r_pending_v <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ldpc_led_reporter.sv
// Bench for ldpc_led_reporter with N=4, TICK_DIV=4 and default tick counts.
// Ticks fall on posedges 4, 8, 12, ... counted from reset release.
module tb_ldpc_led_reporter;
  localparam int N  = 4;
  localparam int IW = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          word_valid = 1'b0;
  logic [N-1:0]  word_data = '0;
  logic          word_ready;
  logic          mode = 1'b1;
  logic          led;
  logic          busy;
  logic [IW-1:0] bit_idx;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  ldpc_led_reporter #(
    .N(N), .TICK_DIV(4), .LONG_TICKS(3), .SHORT_TICKS(1),
    .GAP_TICKS(1), .FRAME_GAP_TICKS(4)
  ) dut (
    .clk(clk), .rst_n(rst_n), .word_valid(word_valid), .word_data(word_data),
    .word_ready(word_ready), .mode(mode), .led(led), .busy(busy),
    .bit_idx(bit_idx)
  );

  always #5 clk = ~clk;

  typedef struct {
    int ticks;
    int led;
    int idx;
    int busy;
  } seg_t;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s at cyc %0d: got %0d want %0d", nm, cyc, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic run_to(input int p);
    while (cyc < p) step();
  endtask

  seg_t segs[10];

  initial begin
    // Frame for 4'b0101: long, gap, short, gap, long, gap, short, gap, fgap,
    // then the first bit of the repeated frame.
    segs[0] = '{3, 1, 0, 1};
    segs[1] = '{1, 0, 0, 1};
    segs[2] = '{1, 1, 1, 1};
    segs[3] = '{1, 0, 1, 1};
    segs[4] = '{3, 1, 2, 1};
    segs[5] = '{1, 0, 2, 1};
    segs[6] = '{1, 1, 3, 1};
    segs[7] = '{1, 0, 3, 1};
    segs[8] = '{4, 0, 3, 1};
    segs[9] = '{3, 1, 0, 1};

    // Reset values
    repeat (2) @(posedge clk);
    #1;
    chk("rst_led", int'(led), 0);
    chk("rst_ready", int'(word_ready), 1);
    chk("rst_busy", int'(busy), 0);
    chk("rst_idx", int'(bit_idx), 0);

    // Release and present A = 0101 in serial mode
    rst_n = 1'b1; cyc = 0; mode = 1'b1;
    word_valid = 1'b1; word_data = 4'b0101;
    step();
    word_valid = 1'b0;
    chk("ready_after_xfer", int'(word_ready), 0);
    run_to(3);
    chk("pretick_led", int'(led), 0);
    chk("pretick_busy", int'(busy), 0);

    for (int s = 0; s < 10; s++) begin
      for (int c = 0; c < segs[s].ticks * 4; c++) begin
        step();
        chk($sformatf("seg%0d_led", s), int'(led), segs[s].led);
        chk($sformatf("seg%0d_idx", s), int'(bit_idx), segs[s].idx);
        chk($sformatf("seg%0d_busy", s), int'(busy), segs[s].busy);
      end
    end

    // Backpressure: B accepted mid-frame, C refused while B is pending
    word_valid = 1'b1; word_data = 4'b0011;
    step();
    word_data = 4'b1010;
    chk("bp_ready_low", int'(word_ready), 0);
    run_to(90);
    word_valid = 1'b0;
    chk("bp_ready_held", int'(word_ready), 0);
    run_to(131);
    chk("bp_ready_before_load", int'(word_ready), 0);
    step();
    chk("bp_ready_after_load", int'(word_ready), 1);
    chk("bp_b_led", int'(led), 1);
    chk("bp_b_idx", int'(bit_idx), 0);
    run_to(156);
    chk("bp_b_bit1_long", int'(led), 1);
    chk("bp_b_bit1_idx", int'(bit_idx), 1);

    // Mode switch during ON of bit 2
    run_to(164);
    chk("ms_on_led", int'(led), 1);
    chk("ms_on_idx", int'(bit_idx), 2);
    chk("ms_on_busy", int'(busy), 1);
    mode = 1'b0;
    run_to(167);
    chk("ms_pre_led", int'(led), 1);
    step();
    chk("ms_led_frame0", int'(led), 1);
    chk("ms_busy", int'(busy), 0);
    chk("ms_idx", int'(bit_idx), 0);
    chk("ms_ready", int'(word_ready), 1);

    // Level mode
    word_valid = 1'b1; word_data = 4'b0110;
    step();
    word_valid = 1'b0;
    chk("lv_ready_low", int'(word_ready), 0);
    run_to(171);
    chk("lv_hold_led", int'(led), 1);
    step();
    chk("lv_led0", int'(led), 0);
    chk("lv_ready_back", int'(word_ready), 1);
    chk("lv_busy0", int'(busy), 0);
    word_valid = 1'b1; word_data = 4'b0001;
    step();
    word_valid = 1'b0;
    run_to(175);
    chk("lv_hold_led2", int'(led), 0);
    step();
    chk("lv_led1", int'(led), 1);
    chk("lv_busy1", int'(busy), 0);
    mode = 1'b1;

    // Back to serial: frame 0001 from the next tick
    run_to(180);
    chk("sr_start_led", int'(led), 1);
    chk("sr_start_busy", int'(busy), 1);
    chk("sr_start_idx", int'(bit_idx), 0);
    run_to(220);
    chk("sr_fgap_led", int'(led), 0);
    chk("sr_fgap_idx", int'(bit_idx), 3);

    // Handshake on the same edge as FGAP expiry with pending empty
    run_to(235);
    word_valid = 1'b1; word_data = 4'b0110;
    step();
    word_valid = 1'b0;
    chk("sim_old_led", int'(led), 1);
    chk("sim_old_idx", int'(bit_idx), 0);
    chk("sim_ready", int'(word_ready), 0);
    run_to(244);
    chk("sim_old_long", int'(led), 1);
    run_to(291);
    chk("sim_ready_wait", int'(word_ready), 0);
    step();
    chk("sim_new_ready", int'(word_ready), 1);
    chk("sim_new_led", int'(led), 1);
    chk("sim_new_idx", int'(bit_idx), 0);
    run_to(296);
    chk("sim_new_short", int'(led), 0);
    run_to(300);
    chk("sim_new_b1_led", int'(led), 1);
    chk("sim_new_b1_idx", int'(bit_idx), 1);

    // Asynchronous reset mid-frame with a word pending
    word_valid = 1'b1; word_data = 4'b1111;
    step();
    word_valid = 1'b0;
    chk("ar_ready_pre", int'(word_ready), 0);
    run_to(308);
    chk("ar_led_pre", int'(led), 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_led", int'(led), 0);
    chk("ar_busy", int'(busy), 0);
    chk("ar_ready", int'(word_ready), 1);
    chk("ar_idx", int'(bit_idx), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/ldpc_led_reporter.md
# ldpc_led_reporter

Parametrised LED result reporter for the LDPC decoder on the iCE40 board. It accepts a corrected codeword from the decoder over a valid/ready handshake and buffers one pending word. It shows the word on a single LED in one of two modes: as a serial long/short blink frame covering all N bits, or as the legacy single-level display of bit 0. It replaces the fixed bit-0, fixed-divider LED logic in the top-level blink design.

## Interface
- N, 10, codeword length in bits (1..32)
- TICK_DIV, 24000000, clk cycles per display tick (≥2)
- LONG_TICKS, 3, LED-on ticks for a 1 bit (≥1)
- SHORT_TICKS, 1, LED-on ticks for a 0 bit (≥1, < LONG_TICKS)
- GAP_TICKS, 1, LED-off ticks after every bit (≥1)
- FRAME_GAP_TICKS, 4, extra LED-off ticks after the last bit's gap (≥1)
- IW, max(1,$clog2(N)), local: index width
- clk  in  1  48 MHz SB_HFOSC clock; the single clock domain
- rst_n  in  1  asynchronous, active-low reset
- word_valid  in  1  decoder presents a codeword
- word_data  in  N  corrected sequence; bit i = corrected_seq[i]
- word_ready  out  1  pending buffer empty; a transfer occurs when word_valid and word_ready are both high at a clk edge
- mode  in  1  0 = level mode (bit 0), 1 = serial frame mode
- led  out  1  LED drive, registered
- busy  out  1  high when the FSM is not in IDLE
- bit_idx  out  IW  index of the bit currently being shown

## Operation
- Tick generator: a free-running counter runs 0..TICK_DIV-1. The tick pulse is high for one cycle when the count equals TICK_DIV-1, and the counter then wraps to 0. State, led and frame changes happen only on tick cycles; the handshake works on every cycle.
- Buffering: a transfer writes word_data into `pending` and sets pending_v. word_ready = !pending_v. pending is copied into `frame` (which sets have_frame) only at a frame-load point, and pending_v clears at that point.
- Level mode (mode=0): the FSM is forced to IDLE. On each tick, if pending_v is set, frame is loaded from pending. led then takes the value of frame[0] from the just-loaded frame, or 0 if have_frame=0. bit_idx=0.
- Serial mode (mode=1) uses the states IDLE, ON, GAP and FGAP. A per-state tick counter counts the duration.
  - IDLE: led=0. On a tick with pending_v or have_frame set, the block loads pending if pending_v is set, then sets idx=0 and moves to ON.
  - ON: led=1 for LONG_TICKS ticks if frame[idx]=1, otherwise for SHORT_TICKS ticks. Then move to GAP.
  - GAP: led=0 for GAP_TICKS ticks. If idx<N-1, increment idx and move to ON; otherwise move to FGAP.
  - FGAP: led=0 for FRAME_GAP_TICKS ticks. Then this is a frame-load point: load pending if pending_v is set, otherwise repeat the current frame. Set idx=0 and move to ON.
- Bits are shown LSB first.
- Mode change is sampled on ticks only.
  - 1→0 mid-frame: abort to IDLE at the next tick, and led=frame[0] on that tick.
  - 0→1: the frame starts at idx 0 on the next tick, following the IDLE rule.
- Simultaneous handshake and load point on the same edge: the load uses the pre-edge pending contents. A word arriving on that edge (possible only when pending_v=0) goes into pending and is not loaded into frame.
- word_data is never sampled without a handshake. A new word never alters a frame that is being displayed.

## Timing
- Reset (async assert, synchronous-deassert use) drives these values: led=0, word_ready=1, busy=0, bit_idx=0, tick counter=0, state=IDLE, pending_v=0, have_frame=0.
- First tick: cycle TICK_DIV-1 after reset release, then every TICK_DIV cycles.
- Handshake: word_ready falls on the edge after a transfer, and rises on the edge after the load point that consumes pending.
- led, busy and bit_idx are registered. They change on the edge at which tick=1.
- Serial frame length in ticks = Σ(on_i + GAP_TICKS) + FRAME_GAP_TICKS.
- Idle to first LED-on latency: the first tick after pending_v is set.

## Test plan
- Reset with TICK_DIV=4: all outputs equal the reset values. Assert rst_n low mid-frame → led=0, busy=0, word_ready=1 asynchronously, without waiting for a clk edge.
- N=4, TICK_DIV=4, defaults, mode=1, send 4'b0101:
  - led high for 12 cycles, low 4, high 4, low 4, high 12, low 4, high 4, low 4+16.
  - The frame then repeats, giving a 64-cycle period.
  - bit_idx steps through 0,1,2,3.
- Backpressure, same setup: send A, then B mid-frame → word_ready=0 after B. Send C while word_ready=0 → C is not accepted. B is shown starting at A's FGAP end, and word_ready=1 on the next edge.
- Mode 0, N=10, send bit0=1 → led=1 from the first tick after the transfer. Then send bit0=0 → led=0 at the next tick. busy stays 0 throughout.
- Mode switch: in mode 1 during ON of bit 2, set mode=0 → at the next tick state=IDLE, led=frame[0], bit_idx=0.
- Simultaneous event: a handshake on the same edge as FGAP expiry with pending_v=0 → the old frame repeats, the new word sits in pending, and it is shown after the next FGAP.
